// File: rtl/decimal_fmt_pkg.sv
// Shared definitions for the decimal interchange-format packer: per-format
// sizing helpers, the special-value code, combination-field constants and
// the packer FSM state type.
package decimal_fmt_pkg;

    // BCD significand digits for a given interchange width (decimal32 / decimal64)
    function automatic int unsigned fmtDigits(input int unsigned fmtW);
        return (fmtW == 64) ? 16 : 7;
    endfunction

    // Biased exponent width
    function automatic int unsigned fmtExpBits(input int unsigned fmtW);
        return (fmtW == 64) ? 10 : 8;
    endfunction

    // Exponent continuation width (exponent minus the two bits held in the combination field)
    function automatic int unsigned fmtContBits(input int unsigned fmtW);
        return fmtExpBits(fmtW) - 2;
    endfunction

    // Number of 10-bit declets following the combination and continuation fields
    function automatic int unsigned fmtDeclets(input int unsigned fmtW);
        return (fmtDigits(fmtW) - 1) / 3;
    endfunction

    typedef enum logic [1:0] {
        SPEC_FINITE = 2'b00,
        SPEC_INF    = 2'b01,
        SPEC_QNAN   = 2'b10,
        SPEC_SNAN   = 2'b11
    } special_e;

    localparam logic [4:0] COMB_INF = 5'b11110;
    localparam logic [4:0] COMB_NAN = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ENC  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/decimal_format_packer_dpd_declet_enc.sv
// Combinational densely-packed-decimal encoder: three BCD digits in,
// one canonical 10-bit declet out, plus a flag for any nibble above 9.
module dpd_declet_enc (
    input  logic [11:0] bcd_i,
    output logic [9:0]  dpd_o,
    output logic        invalid_o
);

    logic a, b, c, d, e, f, g, h, i, j, k, m;

    assign {a, b, c, d} = bcd_i[11:8];
    assign {e, f, g, h} = bcd_i[7:4];
    assign {i, j, k, m} = bcd_i[3:0];

    assign invalid_o = (bcd_i[11:8] > 4'd9) || (bcd_i[7:4] > 4'd9) || (bcd_i[3:0] > 4'd9);

    // Select the declet layout from which digits are large (8/9); unused bits stay zero so the output is canonical
    always_comb begin
        dpd_o = 10'd0;
        case ({a, e, i})
            3'b000: dpd_o = {b, c, d, f, g, h, 1'b0, j, k, m};
            3'b001: dpd_o = {b, c, d, f, g, h, 1'b1, 1'b0, 1'b0, m};
            3'b010: dpd_o = {b, c, d, j, k, h, 1'b1, 1'b0, 1'b1, m};
            3'b011: dpd_o = {b, c, d, 1'b1, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
            3'b100: dpd_o = {j, k, d, f, g, h, 1'b1, 1'b1, 1'b0, m};
            3'b101: dpd_o = {f, g, d, 1'b0, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
            3'b110: dpd_o = {j, k, d, 1'b0, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
            default: dpd_o = {1'b0, 1'b0, d, 1'b1, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
        endcase
    end

endmodule

// File: rtl/decimal_format_packer.sv
// Packs a sign, biased exponent and BCD significand into an IEEE 754-2008
// DPD decimal32/decimal64 word, one declet per cycle through a single
// shared encoder. Special-value inputs (infinity, qNaN, sNaN) are honoured
// only when DECIMAL_PACKER_SPECIAL_EN is defined; otherwise in_special is
// ignored and only overflow / invalid-digit handling remains.
module decimal_format_packer
    import decimal_fmt_pkg::*;
#(
    parameter int unsigned FMT_W = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sign,
    input  logic [fmtExpBits(FMT_W)-1:0]      in_exp,
    input  logic [4*fmtDigits(FMT_W)-1:0]     in_bcd,
    input  logic [1:0]                        in_special,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [FMT_W-1:0]                  out_data,
    output logic [1:0]                        out_flags
);

    localparam int unsigned P      = fmtDigits(FMT_W);
    localparam int unsigned EW     = fmtExpBits(FMT_W);
    localparam int unsigned ECW    = fmtContBits(FMT_W);
    localparam int unsigned N      = fmtDeclets(FMT_W);
    localparam int unsigned DIG_W  = 12 * N;
    localparam int unsigned DECL_W = 10 * N;
    localparam int unsigned IDX_W  = $clog2(N) + 1;

    state_e              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [FMT_W-1:0]    out_data_q;
    logic [1:0]          out_flags_q;

    logic                sign_q;
    logic [EW-1:0]       exp_q;
    logic [3:0]          msd_q;
    logic [DIG_W-1:0]    digits_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DECL_W-1:0]   declAcc_q;
    logic                invAcc_q;

    logic [DECL_W-1:0]   declAcc_d;
    logic                invAcc_d;
    logic [FMT_W-1:0]    result_d;
    logic [1:0]          flags_d;
    logic [4:0]          combField;
    logic                msdInvalid;
    logic [9:0]          encDpd;
    logic                encInvalid;

`ifdef DECIMAL_PACKER_SPECIAL_EN
    special_e            special_q;
`else
    logic                unusedSpecial;
    assign unusedSpecial = ^in_special;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

    assign msdInvalid = (msd_q > 4'd9);

    // The lowest three remaining digits always sit at the bottom of the shift register
    dpd_declet_enc u_enc (
        .bcd_i     (digits_q[11:0]),
        .dpd_o     (encDpd),
        .invalid_o (encInvalid)
    );

    // Next accumulator contents and the final word as it would look if this ENC cycle is the last
    always_comb begin
        declAcc_d = {encDpd, declAcc_q[DECL_W-1:10]};
        invAcc_d  = invAcc_q | encInvalid | msdInvalid;
        combField = msd_q[3] ? {2'b11, exp_q[EW-1 -: 2], msd_q[0]}
                             : {exp_q[EW-1 -: 2], msd_q[2:0]};
        flags_d   = 2'b00;
        result_d  = {sign_q, combField, exp_q[ECW-1:0], declAcc_d};
        if (invAcc_d) begin
            result_d = {sign_q, COMB_NAN, {ECW{1'b0}}, {DECL_W{1'b0}}};
            flags_d  = 2'b10;
        end else if (exp_q[EW-1 -: 2] == 2'b11) begin
            result_d = {sign_q, COMB_INF, {ECW{1'b0}}, {DECL_W{1'b0}}};
            flags_d  = 2'b01;
        end
`ifdef DECIMAL_PACKER_SPECIAL_EN
        case (special_q)
            SPEC_INF: begin
                result_d = {sign_q, COMB_INF, {ECW{1'b0}}, {DECL_W{1'b0}}};
                flags_d  = 2'b00;
            end
            SPEC_QNAN: begin
                result_d = {sign_q, COMB_NAN, 1'b0, {(ECW-1){1'b0}}, declAcc_d};
                flags_d  = 2'b00;
            end
            SPEC_SNAN: begin
                result_d = {sign_q, COMB_NAN, 1'b1, {(ECW-1){1'b0}}, declAcc_d};
                flags_d  = 2'b00;
            end
            default: ;
        endcase
`endif
    end

    // Handshake FSM with registered ready/valid; the result and flags are captured together on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            msd_q       <= '0;
            digits_q    <= '0;
            idx_q       <= '0;
            declAcc_q   <= '0;
            invAcc_q    <= 1'b0;
`ifdef DECIMAL_PACKER_SPECIAL_EN
            special_q   <= SPEC_FINITE;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        sign_q     <= in_sign;
                        exp_q      <= in_exp;
                        msd_q      <= in_bcd[4*P-1 -: 4];
                        digits_q   <= in_bcd[DIG_W-1:0];
                        idx_q      <= '0;
                        declAcc_q  <= '0;
                        invAcc_q   <= 1'b0;
`ifdef DECIMAL_PACKER_SPECIAL_EN
                        special_q  <= special_e'(in_special);
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    digits_q  <= digits_q >> 12;
                    declAcc_q <= declAcc_d;
                    invAcc_q  <= invAcc_d;
                    if (idx_q == IDX_W'(N - 1)) begin
                        out_data_q  <= result_d;
                        out_flags_q <= flags_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_format_packer.sv
// Self-checking bench for decimal_format_packer: a decimal32 and a decimal64
// instance, a table of known encodings, handshake/reset sequences and a
// randomized run against a digit-level reference model.
module tb_decimal_format_packer;

`ifdef DECIMAL_PACKER_SPECIAL_EN
    localparam bit SPECIAL_EN = 1'b1;
`else
    localparam bit SPECIAL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v32, rdy32, sgn32, ov32, ordy32;
    logic [7:0]  exp32;
    logic [27:0] bcd32;
    logic [1:0]  sp32, fl32;
    logic [31:0] data32;

    logic        v64, rdy64, sgn64, ov64, ordy64;
    logic [9:0]  exp64;
    logic [63:0] bcd64;
    logic [1:0]  sp64, fl64;
    logic [63:0] data64;

    int testsRun = 0;
    int testsFailed = 0;

    decimal_format_packer #(.FMT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_sign(sgn32),
        .in_exp(exp32), .in_bcd(bcd32), .in_special(sp32), .out_valid(ov32),
        .out_ready(ordy32), .out_data(data32), .out_flags(fl32)
    );

    decimal_format_packer #(.FMT_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64), .in_sign(sgn64),
        .in_exp(exp64), .in_bcd(bcd64), .in_special(sp64), .out_valid(ov64),
        .out_ready(ordy64), .out_data(data64), .out_flags(fl64)
    );

    typedef struct packed {
        logic        is64;
        logic        sgn;
        logic [9:0]  ex;
        logic [63:0] bcd;
        logic [1:0]  sp;
        logic [63:0] expData;
        logic [1:0]  expFlags;
    } vec_t;

    vec_t vecs[$];

    function automatic logic readyOf(input bit is64);
        return is64 ? rdy64 : rdy32;
    endfunction

    function automatic logic validOf(input bit is64);
        return is64 ? ov64 : ov32;
    endfunction

    function automatic logic [63:0] dataOf(input bit is64);
        return is64 ? data64 : {32'd0, data32};
    endfunction

    function automatic logic [1:0] flagsOf(input bit is64);
        return is64 ? fl64 : fl32;
    endfunction

    // Canonical DPD value of three decimal digits, from which of them are large (8 or 9)
    function automatic int dpdRef(input int d2, input int d1, input int d0);
        int r;
        case ({d2 >= 8, d1 >= 8, d0 >= 8})
            3'b000: r = 128*(d2%8) + 16*(d1%8) + (d0%8);
            3'b001: r = 128*(d2%8) + 16*(d1%8) + 8 + (d0%2);
            3'b010: r = 128*(d2%8) + 16*(((d0/2)%4)*2 + d1%2) + 10 + (d0%2);
            3'b011: r = 128*(d2%8) + 16*(4 + d1%2) + 14 + (d0%2);
            3'b100: r = 128*(((d0/2)%4)*2 + d2%2) + 16*(d1%8) + 12 + (d0%2);
            3'b101: r = 128*(((d1/2)%4)*2 + d2%2) + 16*(2 + d1%2) + 14 + (d0%2);
            3'b110: r = 128*(((d0/2)%4)*2 + d2%2) + 16*(d1%2) + 14 + (d0%2);
            default: r = 128*(d2%2) + 16*(6 + d1%2) + 14 + (d0%2);
        endcase
        return r;
    endfunction

    // Reference encoding: returns {flags, data} built field by field with plain arithmetic
    function automatic logic [65:0] refPack(input bit is64, input logic sgn, input logic [9:0] ex,
                                            input logic [63:0] bcd, input logic [1:0] sp);
        int p, n, ecw, w, expTop, msd, comb;
        int d[16];
        bit bad;
        logic [1:0]  spEff, fl;
        logic [63:0] payload, data, one, signBit;
        p = is64 ? 16 : 7;
        n = (p - 1) / 3;
        ecw = is64 ? 8 : 6;
        w = is64 ? 64 : 32;
        one = 64'd1;
        bad = 1'b0;
        for (int k = 0; k < 16; k++) d[k] = 0;
        for (int k = 0; k < p; k++) begin
            d[k] = int'((bcd >> (4*k)) & 64'hF);
            if (d[k] > 9) bad = 1'b1;
        end
        expTop = int'(ex) >> ecw;
        payload = 64'd0;
        for (int j = 0; j < n; j++) payload = payload | (64'(dpdRef(d[3*j+2], d[3*j+1], d[3*j])) << (10*j));
        spEff = sp & {2{SPECIAL_EN}};
        signBit = sgn ? (one << (w-1)) : 64'd0;
        fl = 2'b00;
        if (spEff == 2'b00) begin
            if (bad) begin
                data = signBit | (64'd31 << (w-6));
                fl = 2'b10;
            end else if (expTop == 3) begin
                data = signBit | (64'd30 << (w-6));
                fl = 2'b01;
            end else begin
                msd = d[p-1];
                comb = (msd < 8) ? expTop*8 + msd : 24 + expTop*2 + msd%2;
                data = signBit | (64'(comb) << (w-6)) | ((64'(ex) % (one << ecw)) << (10*n)) | payload;
            end
        end else if (spEff == 2'b01) begin
            data = signBit | (64'd30 << (w-6));
        end else begin
            data = signBit | (64'd31 << (w-6)) | ((spEff == 2'b11) ? (one << (w-7)) : 64'd0) | payload;
        end
        return {fl, data};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one operand, wait for its result, optionally stall the consumer, then complete the handshake
    task automatic applyStimulus(input bit is64, input logic sgn, input logic [9:0] ex, input logic [63:0] bcd,
                                 input logic [1:0] sp, input int holdCycles,
                                 output logic [63:0] data, output logic [1:0] flags, output int lat);
        int k;
        bit stable;
        data = '0;
        flags = '0;
        lat = 0;
        @(negedge clk);
        if (is64) begin
            v64 = 1'b1; sgn64 = sgn; exp64 = ex; bcd64 = bcd; sp64 = sp;
        end else begin
            v32 = 1'b1; sgn32 = sgn; exp32 = ex[7:0]; bcd32 = bcd[27:0]; sp32 = sp;
        end
        k = 0;
        while (!readyOf(is64) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!readyOf(is64)) begin
            checkOutput("acceptTimeout", {63'd0, readyOf(is64)}, 64'd1);
            v32 = 1'b0; v64 = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0; v64 = 1'b0;
        lat = 1;
        while (!validOf(is64) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!validOf(is64)) begin
            checkOutput("resultTimeout", {63'd0, validOf(is64)}, 64'd1);
            return;
        end
        data = dataOf(is64);
        flags = flagsOf(is64);
        stable = 1'b1;
        for (int hc = 0; hc < holdCycles; hc++) begin
            @(negedge clk);
            if (dataOf(is64) !== data || flagsOf(is64) !== flags || readyOf(is64) !== 1'b0 || validOf(is64) !== 1'b1)
                stable = 1'b0;
        end
        if (holdCycles > 0) checkOutput("holdStable", {63'd0, stable}, 64'd1);
        if (is64) ordy64 = 1'b1; else ordy32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy32 = 1'b0; ordy64 = 1'b0;
        checkOutput("readyAfterHandshake", {63'd0, readyOf(is64)}, 64'd1);
        checkOutput("validDropsAfterHandshake", {63'd0, validOf(is64)}, 64'd0);
    endtask

    initial begin
        logic [63:0] gotData, bcd;
        logic [65:0] model;
        logic [1:0]  gotFlags, sp;
        logic [9:0]  ex;
        int lat, p, dig;
        bit is64, sawValid;

        v32 = 0; sgn32 = 0; exp32 = '0; bcd32 = '0; sp32 = '0; ordy32 = 0;
        v64 = 0; sgn64 = 0; exp64 = '0; bcd64 = '0; sp64 = '0; ordy64 = 0;
        rst_n = 1'b0;

        vecs.push_back('{1'b0, 1'b0, 10'h065, 64'h1234567, 2'b00, 64'h2654D2E7, 2'b00});
        vecs.push_back('{1'b0, 1'b1, 10'h065, 64'h9000000, 2'b00, 64'hEE500000, 2'b00});
        vecs.push_back('{1'b0, 1'b0, 10'h065, 64'h9999999, 2'b00, 64'h6E53FCFF, 2'b00});
        vecs.push_back('{1'b0, 1'b0, 10'h0C0, 64'h1234567, 2'b00, 64'h78000000, 2'b01});
        vecs.push_back('{1'b0, 1'b1, 10'h0C0, 64'h1234567, 2'b00, 64'hF8000000, 2'b01});
        vecs.push_back('{1'b0, 1'b0, 10'h065, 64'h123A567, 2'b00, 64'h7C000000, 2'b10});
        vecs.push_back('{1'b0, 1'b0, 10'h065, 64'hA000000, 2'b00, 64'h7C000000, 2'b10});
        vecs.push_back('{1'b0, 1'b1, 10'h0C0, 64'h123456B, 2'b00, 64'hFC000000, 2'b10});
        vecs.push_back('{1'b0, 1'b0, 10'h000, 64'h8000000, 2'b00, 64'h60000000, 2'b00});
        vecs.push_back('{1'b0, 1'b0, 10'h0BF, 64'h7000000, 2'b00, 64'h5FF00000, 2'b00});
        vecs.push_back('{1'b1, 1'b0, 10'd398, 64'h1, 2'b00, 64'h2238000000000001, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 10'd0, 64'h0, 2'b00, 64'h8000000000000000, 2'b00});
`ifdef DECIMAL_PACKER_SPECIAL_EN
        vecs.push_back('{1'b0, 1'b0, 10'h065, 64'h0000000, 2'b01, 64'h78000000, 2'b00});
        vecs.push_back('{1'b0, 1'b1, 10'h065, 64'h0000123, 2'b10, 64'hFC0000A3, 2'b00});
        vecs.push_back('{1'b0, 1'b0, 10'h065, 64'h0000123, 2'b11, 64'h7E0000A3, 2'b00});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("resetReady32", {63'd0, rdy32}, 64'd0);
        checkOutput("resetValid32", {63'd0, ov32}, 64'd0);
        checkOutput("resetData32", {32'd0, data32}, 64'd0);
        checkOutput("resetFlags64", {62'd0, fl64}, 64'd0);
        checkOutput("resetData64", data64, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterRelease32", {63'd0, rdy32}, 64'd1);
        checkOutput("readyAfterRelease64", {63'd0, rdy64}, 64'd1);

        // Table of known encodings
        foreach (vecs[vi]) begin
            applyStimulus(vecs[vi].is64, vecs[vi].sgn, vecs[vi].ex, vecs[vi].bcd, vecs[vi].sp, 0, gotData, gotFlags, lat);
            checkOutput($sformatf("vecData[%0d]", vi), gotData, vecs[vi].expData);
            checkOutput($sformatf("vecFlags[%0d]", vi), {62'd0, gotFlags}, {62'd0, vecs[vi].expFlags});
            checkOutput($sformatf("vecLatency[%0d]", vi), 64'(lat), vecs[vi].is64 ? 64'd6 : 64'd3);
        end

        // Consumer stall for 5 cycles
        applyStimulus(1'b0, 1'b0, 10'h065, 64'h1234567, 2'b00, 5, gotData, gotFlags, lat);
        checkOutput("stallData", gotData, 64'h2654D2E7);

        // Reset during the second ENC cycle discards the operand
        @(negedge clk);
        v32 = 1'b1; sgn32 = 1'b0; exp32 = 8'h65; bcd32 = 28'h9999999; sp32 = 2'b00;
        checkOutput("midResetReady", {63'd0, rdy32}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetValid", {63'd0, ov32}, 64'd0);
        checkOutput("midResetData", {32'd0, data32}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ov32) sawValid = 1'b1;
        end
        checkOutput("noStaleResult", {63'd0, sawValid}, 64'd0);
        applyStimulus(1'b0, 1'b0, 10'h065, 64'h1234567, 2'b00, 0, gotData, gotFlags, lat);
        checkOutput("postResetData", gotData, 64'h2654D2E7);
        checkOutput("postResetFlags", {62'd0, gotFlags}, 64'd0);

        // Randomized operands against the reference model
        for (int t = 0; t < 60; t++) begin
            is64 = 1'($urandom % 2);
            p = is64 ? 16 : 7;
            sp = 2'($urandom % 4);
            ex = is64 ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 255));
            bcd = '0;
            for (int k = 0; k < p; k++) begin
                dig = ($urandom % 3 == 0) ? $urandom_range(8, 9) : $urandom_range(0, 9);
                if (sp == 2'b00 && $urandom % 12 == 0) dig = $urandom_range(10, 15);
                bcd = bcd | (64'(dig) << (4*k));
            end
            model = refPack(is64, 1'($urandom % 2), ex, bcd, sp);
            applyStimulus(is64, model[63] ^ (is64 ? 1'b0 : 1'b0), ex, bcd, sp, int'($urandom % 3), gotData, gotFlags, lat);
            model = refPack(is64, is64 ? sgn64 : sgn32, ex, bcd, sp);
            checkOutput($sformatf("randData[%0d]", t), gotData, model[63:0]);
            checkOutput($sformatf("randFlags[%0d]", t), {62'd0, gotFlags}, {62'd0, model[65:64]});
            checkOutput($sformatf("randLatency[%0d]", t), 64'(lat), is64 ? 64'd6 : 64'd3);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/decimal_format_packer.md
DECIMAL_FORMAT_PACKER -- requirements
Module: decimal_format_packer

Interface
REQ-001 SHALL provide parameter FMT_W, default 32, meaning interchange width; legal values are 32 (decimal32) and 64 (decimal64).
REQ-002 SHALL derive from FMT_W the following values:
- P (BCD digits): 7 or 16.
- EW (biased exponent bits): 8 or 10.
- ECW (exponent continuation bits): EW-2.
- N (declets): (P-1)/3, giving 2 or 5.
REQ-003 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, operand valid.
REQ-006 SHALL have port in_ready, output, 1 bit, operand accepted when high together with in_valid.
REQ-007 SHALL have port in_sign, input, 1 bit, sign.
REQ-008 SHALL have port in_exp, input, EW bits, biased exponent.
REQ-009 SHALL have port in_bcd, input, 4*P bits, significand in BCD with the MSD in the top nibble.
REQ-010 SHALL have port in_special, input, 2 bits: 00 finite, 01 infinity, 10 qNaN, 11 sNaN.
REQ-011 SHALL have port out_valid, output, 1 bit, result valid.
REQ-012 SHALL have port out_ready, input, 1 bit, consumer ready.
REQ-013 SHALL have port out_data, output, FMT_W bits, IEEE 754-2008 DPD-encoded result.
REQ-014 SHALL have port out_flags, output, 2 bits: [0] exponent overflow, [1] invalid BCD digit.

Function
REQ-015 SHALL implement the FSM IDLE -> ENC -> DONE -> IDLE, with in_ready high only in IDLE.
REQ-016 SHALL, on an accept (IDLE, in_valid&in_ready), register all inputs, clear the declet index, and enter ENC.
REQ-017 SHALL encode one declet per cycle in ENC, least-significant declet first, using the IEEE 754-2008 DPD table; ENC lasts exactly N cycles.
REQ-018 SHALL drive canonical zeros on the don't-care DPD bits (for example, 999 encodes as 0x0FF).
REQ-019 SHALL enter DONE after the N-th ENC cycle and assert out_valid, so out_valid is first high N+1 cycles after the accept edge.
REQ-020 SHALL hold out_data and out_flags stable while out_valid&!out_ready.
REQ-021 SHALL, on out_valid&out_ready, return to IDLE; there is no same-cycle re-accept, giving a peak throughput of one result per N+2 cycles.
REQ-022 SHALL form the combination field from the exponent's top 2 bits (e1e0) and the MSD:
- MSD<=7: {e1e0, MSD[2:0]}.
- MSD 8/9: {2'b11, e1e0, MSD[0]}.
REQ-023 SHALL place the low ECW exponent bits in the continuation field.
REQ-024 SHALL assemble the result as {sign, combination, continuation, declet[N-1..0]}.
REQ-025 SHALL treat exponent top bits 11 (finite input) as overflow: flags[0]=1, result is infinity with the input sign.
REQ-026 SHALL treat any nibble >9 as an invalid digit: flags[1]=1, result is a qNaN with the input sign.
REQ-027 SHALL give the invalid-digit check priority over the overflow check.
REQ-028 SHALL, for infinity, set combination 11110 with the continuation and declets at zero.
REQ-029 SHALL, for qNaN, set combination 11111 with continuation MSB 0; for sNaN, set combination 11111 with continuation MSB 1; in both cases the declets carry the encoded payload.
REQ-030 SHALL keep the out_flags content aligned with out_data and update it only at entry to DONE.

Reset
REQ-031 SHALL, while rst_n is low, force the FSM to IDLE and drive in_ready=0 and out_valid=0, with out_data and out_flags at all zeros.
REQ-032 SHALL drive in_ready high in the first cycle after reset release.
REQ-033 SHALL discard any operand in flight when reset asserts mid-operation; no partial result is ever presented.

Configuration
REQ-034 SHALL use the macro DECIMAL_PACKER_SPECIAL_EN to control special-value handling:
- Defined: in_special is honoured as specified above.
- Undefined: in_special is ignored (treated as 00), NaN/inf generation from in_special is removed, and the REQ-025 and REQ-026 overflow and invalid-digit handling is kept.

Structure
REQ-035 SHALL place the following in a shared package decimal_fmt_pkg:
- Per-format constants P, EW, ECW, N.
- The special-code enumeration.
- The combination-field constants 11110 and 11111.
- The FSM state type.
REQ-036 SHALL implement one declet encoder as the combinational sub-module dpd_declet_enc (12-bit BCD in, 10-bit DPD out, plus a digit-invalid output), instantiated once and time-shared across the ENC cycles.

Verification
REQ-037 SHALL cover decimal32 +1234567 with in_exp=0x65 -> out_data=0x2654D2E7 and flags=00, with out_valid high 3 cycles after the accept.
REQ-038 SHALL cover decimal32 -9000000 with in_exp=0x65 -> 0xEE500000; and +9999999 with in_exp=0x65 -> 0x6E53FCFF (all-large declets are canonical).
REQ-039 SHALL cover decimal32 in_exp=0xC0 (finite) -> 0x78000000 with flags=01; and a nibble 0xA in any digit -> 0x7C000000 with flags=10.
REQ-040 SHALL cover decimal64 +1 with in_exp=398 -> 0x2238000000000001, with out_valid high 6 cycles after the accept.
REQ-041 SHALL cover holding out_ready=0 for 5 cycles -> out_data stable and in_ready low, followed by a single handshake and then in_ready high in the next cycle.
REQ-042 SHALL cover asserting rst_n=0 during the second ENC cycle -> out_valid never asserts for that operand, and the next operand encodes correctly.
